// File: rtl/decode_if.sv
// Fetch-to-decode bundle handshake and per-slot decoded result bus.
// The decode stage sits on the slave side; the fetch/issue logic (or a bench) sits on the master side.
interface decode_if #(
    parameter int ISSUE_W = 2,
    parameter int XLEN    = 32
);
    logic                             flush;
    logic                             in_valid;
    logic                             in_ready;
    logic [ISSUE_W-1:0][31:0]         instr;
    logic                             out_valid;
    logic                             out_ready;
    logic [ISSUE_W-1:0]               out_mask;
    logic [ISSUE_W-1:0][6:0]          opcode;
    logic [ISSUE_W-1:0][4:0]          rd;
    logic [ISSUE_W-1:0][4:0]          rs1;
    logic [ISSUE_W-1:0][4:0]          rs2;
    logic [ISSUE_W-1:0][2:0]          funct3;
    logic [ISSUE_W-1:0][6:0]          funct7;
    logic [ISSUE_W-1:0][XLEN-1:0]     imm;
    logic [ISSUE_W-1:0][7:0]          ctrls;

    modport master (
        output flush, in_valid, instr, out_ready,
        input  in_ready, out_valid, out_mask, opcode, rd, rs1, rs2,
               funct3, funct7, imm, ctrls
    );

    modport slave (
        input  flush, in_valid, instr, out_ready,
        output in_ready, out_valid, out_mask, opcode, rd, rs1, rs2,
               funct3, funct7, imm, ctrls
    );
endinterface

// File: rtl/decode_stage.sv
// N-wide registered RV32I decode stage. Each accepted bundle is decoded into
// registers and issued as one or more groups, split at intra-bundle RAW hazards.
module decode_stage #(
    parameter int ISSUE_W = 2,
    parameter int XLEN    = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    decode_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic {EMPTY, HOLD} state_t;

    // ctrls bit order: illegal, pc_rel, alu_src_imm, jump, branch, mem_write, mem_read, reg_write
    function automatic logic [7:0] ctrl_of(input logic [6:0] op);
        case (op)
            OP_LUI:    return 8'h21;
            OP_AUIPC:  return 8'h61;
            OP_JAL:    return 8'h51;
            OP_JALR:   return 8'h31;
            OP_BRANCH: return 8'h48;
            OP_LOAD:   return 8'h23;
            OP_STORE:  return 8'h24;
            OP_IMM:    return 8'h21;
            OP_REG:    return 8'h01;
            OP_FENCE:  return 8'h00;
            OP_SYSTEM: return 8'h00;
            default:   return 8'h80;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic signed [XLEN-1:0] imm_of(input logic [31:0] ins);
        logic signed [31:0] v;
        case (ins[6:0])
            OP_LUI, OP_AUIPC:
                v = {ins[31:12], 12'b0};
            OP_JAL:
                v = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM:
                v = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:
                v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:
                v = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            default:
                v = '0;
        endcase
        return XLEN'(v);
    endfunction

    state_t                       state_q, state_d;
    logic [ISSUE_W-1:0]           pending_q, pending_d;
    logic [ISSUE_W-1:0][6:0]      opcode_q, funct7_q;
    logic [ISSUE_W-1:0][4:0]      rd_q, rs1_q, rs2_q;
    logic [ISSUE_W-1:0][2:0]      funct3_q;
    logic [ISSUE_W-1:0][XLEN-1:0] imm_q;
    logic [ISSUE_W-1:0][7:0]      ctrls_q;
    logic [ISSUE_W-1:0]           rs2use_q;

    logic [ISSUE_W-1:0] conflict, grp;
    logic               stop, last, load, in_ready, out_valid;

    // Group = pending slots from the oldest pending one up to the first slot
    // that reads a register written by an older pending slot.
    always_comb begin
        conflict = '0;
        grp      = '0;
        stop     = 1'b0;
        for (int j = 0; j < ISSUE_W; j++) begin
            for (int i = 0; i < ISSUE_W; i++) begin
                if (i < j && pending_q[i] && ctrls_q[i][0] && rd_q[i] != 5'd0 &&
                    (rd_q[i] == rs1_q[j] || (rs2use_q[j] && rd_q[i] == rs2_q[j])))
                    conflict[j] = 1'b1;
            end
        end
        for (int j = 0; j < ISSUE_W; j++) begin
            if (pending_q[j] && !stop) begin
                if (conflict[j]) stop   = 1'b1;
                else             grp[j] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        in_ready  = 1'b0;
        load      = 1'b0;
        out_valid = (state_q == HOLD);
        last      = ((pending_q & ~grp) == '0);
        case (state_q)
            EMPTY: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    load      = 1'b1;
                    pending_d = '1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    pending_d = pending_q & ~grp;
                    if (last) begin
                        in_ready = 1'b1;
                        if (bus.in_valid) begin
                            load      = 1'b1;
                            pending_d = '1;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over everything, including a bundle offered in the same cycle.
        if (bus.flush) begin
            in_ready  = 1'b0;
            load      = 1'b0;
            pending_d = '0;
            state_d   = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Decode register: captured once per accepted bundle, held across all its groups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            imm_q    <= '0;
            ctrls_q  <= '0;
            rs2use_q <= '0;
        end else if (load) begin
            for (int s = 0; s < ISSUE_W; s++) begin
                opcode_q[s] <= bus.instr[s][6:0];
                rd_q[s]     <= bus.instr[s][11:7];
                funct3_q[s] <= bus.instr[s][14:12];
                rs1_q[s]    <= bus.instr[s][19:15];
                rs2_q[s]    <= bus.instr[s][24:20];
                funct7_q[s] <= bus.instr[s][31:25];
                imm_q[s]    <= imm_of(bus.instr[s]);
                ctrls_q[s]  <= ctrl_of(bus.instr[s][6:0]);
                rs2use_q[s] <= uses_rs2(bus.instr[s][6:0]);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_mask  = out_valid ? grp : '0;
    assign bus.opcode    = opcode_q;
    assign bus.rd        = rd_q;
    assign bus.rs1       = rs1_q;
    assign bus.rs2       = rs2_q;
    assign bus.funct3    = funct3_q;
    assign bus.funct7    = funct7_q;
    assign bus.imm       = imm_q;
    assign bus.ctrls     = ctrls_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with ISSUE_W=2: decode fields, hazard split,
// backpressure, back-to-back bundles, flush and asynchronous reset.
module tb_decode_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    decode_if #(.ISSUE_W(2), .XLEN(32)) bus ();

    decode_stage #(.ISSUE_W(2), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [31:0] s0, input logic [31:0] s1);
        bus.instr[0] = s0;
        bus.instr[1] = s1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_mask !== 2'b00) begin errors++; $display("FAIL reset_out_mask got %b expected 00", bus.out_mask); end
        checks++; if (bus.ctrls !== 16'h0000) begin errors++; $display("FAIL reset_ctrls got %h expected 0000", bus.ctrls); end
        checks++; if (bus.imm !== 64'h0) begin errors++; $display("FAIL reset_imm got %h expected 0", bus.imm); end
    endtask

    task automatic test_basic();
        load(32'h00500093, 32'h00202423);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_mask !== 2'b11) begin errors++; $display("FAIL basic_mask got %b expected 11", bus.out_mask); end
        checks++; if (bus.rd[0] !== 5'd1) begin errors++; $display("FAIL basic_rd0 got %0d expected 1", bus.rd[0]); end
        checks++; if (bus.imm[0] !== 32'd5) begin errors++; $display("FAIL basic_imm0 got %h expected 00000005", bus.imm[0]); end
        checks++; if (bus.ctrls[0] !== 8'h21) begin errors++; $display("FAIL basic_ctrls0 got %h expected 21", bus.ctrls[0]); end
        checks++; if (bus.rs2[1] !== 5'd2) begin errors++; $display("FAIL basic_rs2_1 got %0d expected 2", bus.rs2[1]); end
        checks++; if (bus.imm[1] !== 32'd8) begin errors++; $display("FAIL basic_imm1 got %h expected 00000008", bus.imm[1]); end
        checks++; if (bus.ctrls[1] !== 8'h24) begin errors++; $display("FAIL basic_ctrls1 got %h expected 24", bus.ctrls[1]); end
        checks++; if (bus.funct3[1] !== 3'b010) begin errors++; $display("FAIL basic_funct3_1 got %b expected 010", bus.funct3[1]); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b expected 1", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_split();
        load(32'h00500093, 32'h00108133);
        checks++; if (bus.out_mask !== 2'b01) begin errors++; $display("FAIL split_mask_a got %b expected 01", bus.out_mask); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL split_in_ready_a got %b expected 0", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL split_valid_b got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_mask !== 2'b10) begin errors++; $display("FAIL split_mask_b got %b expected 10", bus.out_mask); end
        checks++; if (bus.rd[1] !== 5'd2) begin errors++; $display("FAIL split_rd1 got %0d expected 2", bus.rd[1]); end
        checks++; if (bus.ctrls[1] !== 8'h01) begin errors++; $display("FAIL split_ctrls1 got %h expected 01", bus.ctrls[1]); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL split_in_ready_b got %b expected 1", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL split_drain got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_x0_and_illegal();
        load(32'h00000013, 32'h00000133);
        checks++; if (bus.out_mask !== 2'b11) begin errors++; $display("FAIL x0_mask got %b expected 11", bus.out_mask); end
        step();
        load(32'hFFFFFFFF, 32'h00000013);
        checks++; if (bus.out_mask !== 2'b11) begin errors++; $display("FAIL illegal_mask got %b expected 11", bus.out_mask); end
        checks++; if (bus.ctrls[0] !== 8'h80) begin errors++; $display("FAIL illegal_ctrls got %h expected 80", bus.ctrls[0]); end
        checks++; if (bus.imm[0] !== 32'h0) begin errors++; $display("FAIL illegal_imm got %h expected 00000000", bus.imm[0]); end
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        load(32'hFFC12183, 32'h00000013);
        bus.instr[0] = 32'h00000013;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b expected 0", c, bus.in_ready); end
            checks++; if (bus.out_mask !== 2'b11) begin errors++; $display("FAIL bp_mask cyc %0d got %b expected 11", c, bus.out_mask); end
            checks++; if (bus.imm[0] !== 32'hFFFFFFFC) begin errors++; $display("FAIL bp_imm0 cyc %0d got %h expected fffffffc", c, bus.imm[0]); end
            checks++; if (bus.ctrls[0] !== 8'h23) begin errors++; $display("FAIL bp_ctrls0 cyc %0d got %h expected 23", c, bus.ctrls[0]); end
            checks++; if (bus.rd[0] !== 5'd3) begin errors++; $display("FAIL bp_rd0 cyc %0d got %0d expected 3", c, bus.rd[0]); end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b expected 1", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        bus.instr[0] = 32'h00500093;
        bus.instr[1] = 32'h00202423;
        bus.in_valid = 1'b1;
        step();
        bus.instr[0] = 32'h123452B7;
        bus.instr[1] = 32'h00000013;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_a got %b expected 1", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_a got %b expected 1", bus.in_ready); end
        checks++; if (bus.rd[0] !== 5'd1) begin errors++; $display("FAIL b2b_rd0_a got %0d expected 1", bus.rd[0]); end
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_b got %b expected 1", bus.out_valid); end
        checks++; if (bus.rd[0] !== 5'd5) begin errors++; $display("FAIL b2b_rd0_b got %0d expected 5", bus.rd[0]); end
        checks++; if (bus.imm[0] !== 32'h12345000) begin errors++; $display("FAIL b2b_imm0_b got %h expected 12345000", bus.imm[0]); end
        checks++; if (bus.ctrls[0] !== 8'h21) begin errors++; $display("FAIL b2b_ctrls0_b got %h expected 21", bus.ctrls[0]); end
        bus.instr[0] = 32'h008000EF;
        bus.instr[1] = 32'hFE000EE3;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_c got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_mask !== 2'b11) begin errors++; $display("FAIL b2b_mask_c got %b expected 11", bus.out_mask); end
        checks++; if (bus.imm[0] !== 32'h00000008) begin errors++; $display("FAIL b2b_imm0_c got %h expected 00000008", bus.imm[0]); end
        checks++; if (bus.ctrls[0] !== 8'h51) begin errors++; $display("FAIL b2b_ctrls0_c got %h expected 51", bus.ctrls[0]); end
        checks++; if (bus.imm[1] !== 32'hFFFFFFFC) begin errors++; $display("FAIL b2b_imm1_c got %h expected fffffffc", bus.imm[1]); end
        checks++; if (bus.ctrls[1] !== 8'h48) begin errors++; $display("FAIL b2b_ctrls1_c got %h expected 48", bus.ctrls[1]); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        load(32'h00500093, 32'h00108133);
        checks++; if (bus.out_mask !== 2'b01) begin errors++; $display("FAIL flush_pre_mask got %b expected 01", bus.out_mask); end
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr[0] = 32'h123452B7;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b expected 0", bus.in_ready); end
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_mask !== 2'b00) begin errors++; $display("FAIL flush_out_mask got %b expected 00", bus.out_mask); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready_after got %b expected 1", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        load(32'h00500093, 32'h00202423);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %b expected 1", bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_mask !== 2'b00) begin errors++; $display("FAIL areset_mask got %b expected 00", bus.out_mask); end
        checks++; if (bus.rd[0] !== 5'd0) begin errors++; $display("FAIL areset_rd0 got %0d expected 0", bus.rd[0]); end
        checks++; if (bus.imm[0] !== 32'h0) begin errors++; $display("FAIL areset_imm0 got %h expected 00000000", bus.imm[0]); end
        checks++; if (bus.ctrls !== 16'h0000) begin errors++; $display("FAIL areset_ctrls got %h expected 0000", bus.ctrls); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got %b expected 1", bus.in_ready); end
        #2;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_after got %b expected 0", bus.out_valid); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        clk           = 1'b0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.out_ready = 1'b1;
        #3;
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_split();
        test_x0_and_illegal();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
